// File: rtl/param_serial_div_pkg.sv
// Shared state codes and handshake constants for the parametrised serial divider.
package param_serial_div_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/param_serial_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module param_serial_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // One extra bit holds the borrow: the remainder is always below the divisor,
  // so the shifted value is below twice the divisor and fits in WIDTH+1 bits.
  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, divisor_i};
  assign q_o     = ~diff[WIDTH];
  assign rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/param_serial_div.sv
// Iterative signed/unsigned divider producing STEPS quotient bits per cycle.
module param_serial_div
  import param_serial_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_zero_o
);

  localparam int N     = WIDTH / STEPS;
  localparam int CNT_W = $clog2(N) + 1;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, dvd_q, dsr_q;
  logic             sgn_mode_q, sgn1_q, sgn2_q;

  logic             accept, last;
  logic [WIDTH-1:0] rem_chain [STEPS+1];
  logic [STEPS-1:0] q_bits;
  logic [WIDTH-1:0] dvd_next, q_fix, r_fix;

  assign accept = (start_i == DIV_START) && !annul_i;
  assign last   = (cnt_q == CNT_W'(N - 1));

  // Quotient bits are shifted into the low end of the dividend register as it empties.
  assign rem_chain[0] = rem_q;
  for (genvar k = 0; k < STEPS; k++) begin : g_step
    param_serial_div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_chain[k]),
      .bit_i     (dvd_q[WIDTH-1-k]),
      .divisor_i (dsr_q),
      .rem_o     (rem_chain[k+1]),
      .q_o       (q_bits[STEPS-1-k])
    );
  end
  assign dvd_next = (dvd_q << STEPS) | WIDTH'(q_bits);

  // Most-negative / -1 needs no special case: its magnitude quotient negates to itself.
  assign q_fix = (sgn_mode_q && (sgn1_q ^ sgn2_q)) ? -dvd_next : dvd_next;
  assign r_fix = (sgn_mode_q && sgn1_q) ? -rem_chain[STEPS] : rem_chain[STEPS];

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: every register written here uses <= so all flops sample the same pre-edge values.
    if (!rst) state_q <= DIV_FREE;
    else      state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      DIV_FREE:    if (accept) state_d = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
      DIV_BY_ZERO: state_d = annul_i ? DIV_FREE : DIV_END;
      DIV_ON:      if (annul_i) state_d = DIV_FREE;
                   else if (last) state_d = DIV_END;
      DIV_END:     if (start_i == DIV_STOP) state_d = DIV_FREE;
      default:     state_d = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dsr_q      <= '0;
      sgn_mode_q <= 1'b0;
      sgn1_q     <= 1'b0;
      sgn2_q     <= 1'b0;
      result_o   <= '0;
      div_zero_o <= 1'b0;
    end else begin
      unique case (state_q)
        DIV_FREE: if (accept) begin
          sgn_mode_q <= signed_div_i;
          sgn1_q     <= opdata1_i[WIDTH-1];
          sgn2_q     <= opdata2_i[WIDTH-1];
          rem_q      <= '0;
          dvd_q      <= (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
          dsr_q      <= (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
          cnt_q      <= '0;
        end
        DIV_BY_ZERO: if (!annul_i) begin
          result_o   <= '0;
          div_zero_o <= 1'b1;
        end
        DIV_ON: if (!annul_i) begin
          rem_q <= rem_chain[STEPS];
          dvd_q <= dvd_next;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last) begin
            result_o   <= {r_fix, q_fix};
            div_zero_o <= 1'b0;
          end
        end
        DIV_END: if (start_i == DIV_STOP) begin
          result_o   <= '0;
          div_zero_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign ready_o = (state_q == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
  assign busy_o  = (state_q == DIV_BY_ZERO) || (state_q == DIV_ON);

endmodule

// File: tb/tb_param_serial_div.sv
// Directed, table-driven bench for param_serial_div (STEPS=1 and STEPS=2 instances).
module tb_param_serial_div;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] op1 = '0, op2 = '0;
  logic        start1 = 1'b0, start2 = 1'b0, annul = 1'b0;
  logic [63:0] res1, res2;
  logic        rdy1, rdy2, bsy1, bsy2, dz1, dz2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  param_serial_div #(.WIDTH(32), .STEPS(1)) dut1 (
    .clk(clk), .rst(rst), .signed_div_i(signed_div), .opdata1_i(op1), .opdata2_i(op2),
    .start_i(start1), .annul_i(annul), .result_o(res1), .ready_o(rdy1), .busy_o(bsy1),
    .div_zero_o(dz1)
  );

  param_serial_div #(.WIDTH(32), .STEPS(2)) dut2 (
    .clk(clk), .rst(rst), .signed_div_i(signed_div), .opdata1_i(op1), .opdata2_i(op2),
    .start_i(start2), .annul_i(annul), .result_o(res2), .ready_o(rdy2), .busy_o(bsy2),
    .div_zero_o(dz2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("excl1", 64'(rdy1 && bsy1), 64'd0);
      check("excl2", 64'(rdy2 && bsy2), 64'd0);
    end
  end

  // Drives operands and raises start at a falling edge, then returns just after the start edge.
  task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b, input bit use2);
    @(negedge clk);
    annul = 1'b0;
    signed_div = s;
    op1 = a;
    op2 = b;
    if (use2) start2 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
  endtask

  // Counts edges after the start edge until ready (bounded); busy samples counted on the way.
  task automatic wait_done(input bit use2, output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (use2 ? rdy2 : rdy1) break;
      if (use2 ? bsy2 : bsy1) busy_n++;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic finish_op(input bit use2);
    @(negedge clk);
    if (use2) start2 = 1'b0; else start1 = 1'b0;
    op1 = 32'hDEAD_BEEF;
    op2 = 32'h0;
    @(posedge clk);
    #1;
    check("clr_ready", 64'(use2 ? rdy2 : rdy1), 64'd0);
    check("clr_result", use2 ? res2 : res1, 64'd0);
    check("clr_dz", 64'(use2 ? dz2 : dz1), 64'd0);
  endtask

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int          lat, busy_n;
    logic [63:0] held;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};
    vecs[2]  = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0};
    vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    vecs[4]  = '{1'b0, 32'hFFFF_FFFF,  32'd3,          32'h5555_5555,  32'd0,          1'b0};
    vecs[5]  = '{1'b0, 32'h0000_1234,  32'd0,          32'd0,          32'd0,          1'b1};
    vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
    vecs[7]  = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5,          1'b0};
    vecs[8]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0};
    vecs[9]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
    vecs[10] = '{1'b1, 32'hFFFF_FFFF,  32'd0,          32'd0,          32'd0,          1'b1};
    vecs[11] = '{1'b1, 32'd7,          32'd2,          32'd3,          32'd1,          1'b0};

    // Reset values while rst is asserted.
    #12;
    check("rst_result", res1, 64'd0);
    check("rst_ready", 64'(rdy1), 64'd0);
    check("rst_busy", 64'(bsy1), 64'd0);
    check("rst_dz", 64'(dz1), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_ready", 64'(rdy1), 64'd0);
    check("idle_result", res1, 64'd0);

    foreach (vecs[i]) begin
      start_op(vecs[i].s, vecs[i].a, vecs[i].b, 1'b0);
      wait_done(1'b0, lat, busy_n);
      check($sformatf("v%0d_latency", i), 64'(lat), vecs[i].dz ? 64'd1 : 64'd32);
      check($sformatf("v%0d_busy_cycles", i), 64'(busy_n), vecs[i].dz ? 64'd1 : 64'd32);
      check($sformatf("v%0d_result", i), res1, {vecs[i].r, vecs[i].q});
      check($sformatf("v%0d_dz", i), 64'(dz1), 64'(vecs[i].dz));
      if (i == 0) begin
        held = {vecs[i].r, vecs[i].q};
        for (int c = 0; c < 5; c++) begin
          @(posedge clk);
          #1;
          check("hold_ready", 64'(rdy1), 64'd1);
          check("hold_result", res1, held);
        end
      end
      finish_op(1'b0);
    end

    // Annul mid-operation, then an immediate restart.
    start_op(1'b0, 32'hFFFF_FFFF, 32'd3, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("annul_busy_before", 64'(bsy1), 64'd1);
    annul = 1'b1;
    start1 = 1'b0;
    @(posedge clk);
    #1;
    check("annul_busy", 64'(bsy1), 64'd0);
    check("annul_ready", 64'(rdy1), 64'd0);
    check("annul_result", res1, 64'd0);
    start_op(1'b0, 32'd9, 32'd3, 1'b0);
    wait_done(1'b0, lat, busy_n);
    check("restart_latency", 64'(lat), 64'd32);
    check("restart_result", res1, {32'd0, 32'd3});
    finish_op(1'b0);

    // STEPS=2 instance: half the latency, same answer.
    start_op(1'b0, 32'd100, 32'd7, 1'b1);
    wait_done(1'b1, lat, busy_n);
    check("s2_latency", 64'(lat), 64'd16);
    check("s2_result", res2, {32'd2, 32'd14});
    check("s2_dz", 64'(dz2), 64'd0);
    finish_op(1'b1);

    // Asynchronous reset in the middle of an operation, start held throughout.
    start_op(1'b0, 32'd100, 32'd7, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", 64'(bsy1), 64'd0);
    check("arst_ready", 64'(rdy1), 64'd0);
    check("arst_result", res1, 64'd0);
    check("arst_dz", 64'(dz1), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    wait_done(1'b0, lat, busy_n);
    check("arst_latency", 64'(lat), 64'd32);
    check("arst_final", res1, {32'd2, 32'd14});
    finish_op(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
